// File: rtl/bitvec_link_pkg.sv
// Shared types and constants for the bit-vector link controller.
// Optional continuous dumping is selected by BITVEC_LINK_AUTO_DUMP_EN in bitvec_link_ctrl.
package bitvec_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAPTURE,
    ST_SEND,
    ST_TERM
  } state_e;

  localparam logic [7:0] ZERO     = 8'h30;
  localparam logic [7:0] TERM     = 8'h2A;
  localparam logic [6:0] CMD_ADDR = 7'd127;

  // Host command byte: bit address in [7:1], value in [0]
  typedef struct packed {
    logic [6:0] addr;
    logic       value;
  } rx_cmd_t;

  function automatic logic [7:0] ascii_bit(input logic b);
    return ZERO + 8'(b);
  endfunction

endpackage

// File: rtl/bitvec_link_ctrl_settle_timer.sv
// Settle timer: counts stable cycles after the stimulus vector last changed.
// settled goes high once SETTLE stable cycles have elapsed since the last load.
module settle_timer #(
  parameter int unsigned SETTLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic stable,
  output logic settled
);

  localparam int unsigned   CW     = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          settled_q, settled_d;

  // Reload on change, otherwise count down to zero and hold
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (stable && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
    settled_d = !load && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= RELOAD;
      settled_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      settled_q <= settled_d;
    end
  end

  assign settled = settled_q;

endmodule

// File: rtl/bitvec_link_ctrl.sv
// Host-driven stimulus/readback controller: bytes set bits of in_vec, dumps stream out_vec as ASCII.
// Define BITVEC_LINK_AUTO_DUMP_EN for a permanently pending dump request (continuous stream).
module bitvec_link_ctrl
  import bitvec_link_pkg::*;
#(
  parameter int unsigned IL     = 64,
  parameter int unsigned OL     = 64,
  parameter int unsigned SETTLE = 16
) (
  input  logic          clk_48mhz,
  input  logic          reset_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [IL-1:0] in_vec,
  input  logic [OL-1:0] out_vec,
  output logic          settled,
  output logic          busy
);

  localparam int unsigned     CURW     = $clog2(OL + 1);
  localparam logic [CURW-1:0] LAST_BIT = CURW'(OL - 1);

  state_e          state_q, state_d;
  logic [IL-1:0]   in_vec_q, in_vec_d;
  logic [OL-1:0]   snap_q, snap_d;
  logic [OL-1:0]   snap_sh;
  logic [CURW-1:0] cur_q, cur_d;
  logic            req_q, req_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            rx_ready_q;
  logic            busy_q, busy_d;

  rx_cmd_t rx_cmd;
  logic    rx_acc;
  logic    tx_hs;
  logic    vec_load;
  logic    settled_w;

  assign rx_cmd = rx_cmd_t'(rx_data);
  assign rx_acc = rx_valid && rx_ready_q;
  assign tx_hs  = tx_valid_q && tx_ready;

  // Host write decode: bit writes below IL, command address clears on value 0
  always_comb begin
    in_vec_d = in_vec_q;
    if (rx_acc) begin
      if (rx_cmd.addr == CMD_ADDR) begin
        if (!rx_cmd.value) begin
          in_vec_d = '0;
        end
      end else begin
        for (int unsigned i = 0; i < IL; i++) begin
          if (rx_cmd.addr == 7'(i)) begin
            in_vec_d[i] = rx_cmd.value;
          end
        end
      end
    end
  end

  // Only a real change of in_vec restarts the settle interval
  assign vec_load = (in_vec_d != in_vec_q);

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk     (clk_48mhz),
    .rst_n   (reset_n),
    .load    (vec_load),
    .stable  (!vec_load),
    .settled (settled_w)
  );

  // Dump sequencer; tx outputs are computed one cycle ahead so they leave registered
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    cur_d      = cur_q;
    req_d      = req_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    snap_sh    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_q) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (settled_w) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        snap_d     = out_vec;
        cur_d      = '0;
        req_d      = 1'b0;
        tx_valid_d = 1'b1;
        tx_data_d  = ascii_bit(out_vec[0]);
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (tx_hs) begin
          cur_d = cur_q + CURW'(1);
          if (cur_q == LAST_BIT) begin
            tx_data_d = TERM;
            state_d   = ST_TERM;
          end else begin
            snap_sh   = snap_q >> cur_d;
            tx_data_d = ascii_bit(snap_sh[0]);
          end
        end
      end
      ST_TERM: begin
        if (tx_hs) begin
          tx_valid_d = 1'b0;
          state_d    = req_q ? ST_WAIT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new request wins over the capture-cycle clear so it is never dropped
    if (rx_acc && (rx_cmd.addr == CMD_ADDR) && rx_cmd.value) begin
      req_d = 1'b1;
    end
`ifdef BITVEC_LINK_AUTO_DUMP_EN
    req_d = 1'b1;
`endif
  end

  assign busy_d = (state_d == ST_CAPTURE) || (state_d == ST_SEND) || (state_d == ST_TERM);

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      in_vec_q   <= '0;
      snap_q     <= '0;
      cur_q      <= '0;
      req_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_vec_q   <= in_vec_d;
      snap_q     <= snap_d;
      cur_q      <= cur_d;
      req_q      <= req_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      rx_ready_q <= 1'b1;
      busy_q     <= busy_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign in_vec   = in_vec_q;
  assign settled  = settled_w;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bitvec_link_ctrl.sv
// Randomized scoreboard bench for bitvec_link_ctrl (default build, no auto dump).
module tb_bitvec_link_ctrl;

  localparam int unsigned IL     = 64;
  localparam int unsigned OL     = 64;
  localparam int unsigned SETTLE = 16;
  localparam logic [63:0] MASK   = 64'hC3A5_0F96_5A3C_E187;

  logic          clk_48mhz = 1'b0;
  logic          reset_n   = 1'b0;
  logic [7:0]    rx_data   = 8'h00;
  logic          rx_valid  = 1'b0;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready  = 1'b0;
  logic [IL-1:0] in_vec;
  logic [OL-1:0] out_vec;
  logic          settled;
  logic          busy;

  int cmps = 0;
  int errs = 0;
  int hs_cnt = 0;
  int rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled

  logic [7:0]    exp_q[$];
  logic [IL-1:0] m_in     = '0;
  logic [IL-1:0] m_nxt    = '0;
  int            m_stable = 0;
  logic          m_rdy    = 1'b0;
  int            m_addr;
  logic          p_valid  = 1'b0;
  logic          p_ready  = 1'b0;

  bitvec_link_ctrl #(.IL(IL), .OL(OL), .SETTLE(SETTLE)) dut (
    .clk_48mhz (clk_48mhz),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .in_vec    (in_vec),
    .out_vec   (out_vec),
    .settled   (settled),
    .busy      (busy)
  );

  // Emulated asynchronous logic block
  function automatic logic [OL-1:0] async_fn(input logic [IL-1:0] v);
    return (v ^ {v[0], v[IL-1:1]}) ^ MASK;
  endfunction

  assign out_vec = async_fn(in_vec);

  always #5 clk_48mhz = ~clk_48mhz;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: vector contents, stable-cycle count, ready flag
  always @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      m_in = '0;
      m_stable = 0;
      m_rdy = 1'b0;
    end else begin
      m_nxt = m_in;
      if (rx_valid && m_rdy) begin
        m_addr = int'(rx_data[7:1]);
        if (m_addr < int'(IL)) m_nxt[m_addr] = rx_data[0];
        else if (m_addr == 127 && !rx_data[0]) m_nxt = '0;
      end
      if (m_nxt != m_in) m_stable = 0;
      else if (m_stable < 100000) m_stable = m_stable + 1;
      m_in = m_nxt;
      m_rdy = 1'b1;
    end
  end

  // Monitor: per-cycle state checks and scoreboard pop on each tx handshake
  always @(negedge clk_48mhz) begin
    if (!reset_n) begin
      p_valid = 1'b0;
      p_ready = 1'b0;
    end else begin
      chk("rx_ready", 128'(rx_ready), 128'(m_rdy));
      chk("in_vec", 128'(in_vec), 128'(m_in));
      chk("settled", 128'(settled), 128'(m_stable >= int'(SETTLE)));
      if (p_valid && !p_ready) begin
        chk("hold_valid", 128'(tx_valid), 128'(1));
        if (exp_q.size() != 0) chk("hold_data", 128'(tx_data), 128'(exp_q[0]));
      end
      if (tx_valid && !p_valid)
        chk("capture_after_settle", 128'(m_stable >= int'(SETTLE)), 128'(1));
      if (tx_valid && tx_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          cmps++;
          errs++;
          $display("FAIL unexpected_tx: actual=%0h expected=none at %0t", tx_data, $time);
        end else begin
          chk("tx_byte", 128'(tx_data), 128'(exp_q.pop_front()));
        end
      end
      p_valid = tx_valid;
      p_ready = tx_ready;
    end
  end

  // tx_ready driver, applied shortly after each edge
  initial begin
    forever begin
      @(posedge clk_48mhz);
      #2;
      case (rdy_mode)
        0: tx_ready = ($urandom_range(0, 3) != 0);
        1: tx_ready = 1'b1;
        default: tx_ready = 1'b0;
      endcase
    end
  end

  initial begin
    repeat (90000) @(posedge clk_48mhz);
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_48mhz);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
  endtask

  task automatic push_dump();
    logic [OL-1:0] v;
    v = async_fn(m_in);
    for (int i = 0; i < int'(OL); i++) exp_q.push_back(8'h30 + 8'(v[i]));
    exp_q.push_back(8'h2A);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_valid || busy) && n < max_cyc) begin
      cyc(1);
      n++;
    end
    cmps++;
    if (n >= max_cyc) begin
      errs++;
      $display("FAIL drain: actual=%0d bytes pending expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle();
    cyc(SETTLE + 6);
    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_tx_valid", 128'(tx_valid), 128'(0));
  endtask

  task automatic wait_hs(input int target, input int max_cyc);
    int n;
    n = 0;
    while (hs_cnt < target && n < max_cyc) begin
      cyc(1);
      n++;
    end
    chk("hs_reached", 128'(hs_cnt >= target), 128'(1));
  endtask

  initial begin
    int lat;
    int base;
    int h0;
    logic [IL-1:0] v0;
    logic [7:0] b;
    int k;

    // Reset values
    #3;
    chk("rst_rx_ready", 128'(rx_ready), 128'(0));
    chk("rst_tx_valid", 128'(tx_valid), 128'(0));
    chk("rst_tx_data", 128'(tx_data), 128'(0));
    chk("rst_in_vec", 128'(in_vec), 128'(0));
    chk("rst_settled", 128'(settled), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    cyc(3);
    reset_n = 1'b1;
    cyc(2);

    // Basic dump: bit 5 set, then request with ready held high
    rdy_mode = 1;
    send_byte(8'hFE);
    send_byte(8'h0B);
    lat = 0;
    send_byte(8'hFF);
    push_dump();
    lat = 1;
    while (!tx_valid && lat < 200) begin
      cyc(1);
      lat++;
    end
    chk("dump_latency_min", 128'(lat >= int'(SETTLE)), 128'(1));
    chk("dump_latency_max", 128'(lat <= int'(SETTLE) + 4), 128'(1));
    wait_drain(400);
    check_idle();

    // Ignored address and clear
    send_byte(8'h11);
    send_byte(8'h21);
    v0 = m_in;
    send_byte(8'h90);
    chk("ignored_addr", 128'(in_vec), 128'(v0));
    send_byte(8'hFE);
    chk("clear_cmd", 128'(in_vec), 128'(0));
    send_byte(8'h7F);
    cyc(2);

    // Stall the host in the middle of SEND
    base = hs_cnt;
    send_byte(8'hFF);
    push_dump();
    wait_hs(base + 10, 300);
    rdy_mode = 2;
    cyc(1);
    h0 = hs_cnt;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("stall_valid", 128'(tx_valid), 128'(1));
      if (exp_q.size() != 0) chk("stall_data", 128'(tx_data), 128'(exp_q[0]));
    end
    chk("stall_no_hs", 128'(hs_cnt), 128'(h0));
    rdy_mode = 1;
    wait_drain(400);
    check_idle();

    // Writes keep changing in_vec while a dump waits: capture only after they stop
    send_byte({7'd1, ~m_in[1]});
    send_byte(8'hFF);
    for (int i = 0; i < 6; i++) begin
      cyc(3);
      send_byte({7'd1, ~m_in[1]});
    end
    push_dump();
    wait_drain(400);
    check_idle();

    // Requests and writes during SEND: one extra dump, from the updated vector
    send_byte(8'hFF);
    push_dump();
    lat = 0;
    while (!tx_valid && lat < 200) begin
      cyc(1);
      lat++;
    end
    send_byte(8'hFF);
    send_byte({7'd3, ~m_in[3]});
    send_byte(8'hFF);
    push_dump();
    wait_drain(600);
    check_idle();

    // Reset in the middle of a dump
    send_byte(8'h25);
    base = hs_cnt;
    send_byte(8'hFF);
    push_dump();
    wait_hs(base + 30, 300);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_tx_valid", 128'(tx_valid), 128'(0));
    chk("abort_in_vec", 128'(in_vec), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    cyc(3);
    reset_n = 1'b1;
    cyc(2);
    send_byte(8'h0B);
    send_byte(8'hFF);
    push_dump();
    wait_drain(400);
    check_idle();

    // Randomized traffic
    for (int r = 0; r < 20; r++) begin
      rdy_mode = int'($urandom_range(0, 1));
      for (int w = 0; w < int'($urandom_range(1, 8)); w++) begin
        k = int'($urandom_range(0, 19));
        if (k < 14) b = {7'($urandom_range(0, IL - 1)), 1'($urandom_range(0, 1))};
        else if (k < 18) b = {7'($urandom_range(IL, 126)), 1'($urandom_range(0, 1))};
        else b = 8'hFE;
        send_byte(b);
        cyc(int'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 9) < 6) begin
        send_byte(8'hFF);
        push_dump();
        wait_drain(800);
        check_idle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
